// File: rtl/sw_arb_pkg.sv
// Shared types and constants for the switch round-robin arbiter.
// State encoding, button indices and quantum limits.
package sw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    PAUSE
  } state_t;

  localparam int BTN_PAUSE = 0;
  localparam int BTN_SKIP  = 1;
  localparam int BTN_QUP   = 2;
  localparam int BTN_QDN   = 3;
  localparam int BTN_MODE  = 4;

  localparam int Q_MIN = 1;
  localparam int Q_MAX = 15;

endpackage

// File: rtl/sw_rr_arbiter_pick.sv
// Combinational winner selection over eight requesters.
// mode=0 rotates from last+1, mode=1 takes the highest set index.
module arb_pick (
  input  logic [7:0] req,
  input  logic [2:0] last,
  input  logic       mode,
  output logic [2:0] idx,
  output logic       any
);

  logic [2:0] j;

  always_comb begin
    idx = '0;
    j   = '0;
    any = |req;
    if (mode) begin
      for (int i = 0; i < 8; i++)
        if (req[i]) idx = 3'(i);
    end else begin
      // Walk offsets 8..1 so the nearest one after last wins.
      for (int i = 8; i >= 1; i--) begin
        j = last + 3'(i);
        if (req[j]) idx = j;
      end
    end
  end

endmodule

// File: rtl/sw_rr_arbiter.sv
// Quantum-based grant sequencer above the switch encoder.
// Synchronizes sw/btn, runs the grant FSM and drives the LEDs.
module sw_rr_arbiter
  import sw_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int QW    = 4,
  parameter int Q_RST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    btn,
  input  logic [N-1:0]  sw,
  output logic [N-1:0]  gnt,
  output logic [2:0]    gnt_idx,
  output logic          gnt_valid,
  output logic [15:0]   ledr
);

  logic [N-1:0]  sw_s1, sw_s2;
  logic [4:0]    btn_s1, btn_s2, btn_d, ev;
  logic [QW-1:0] quantum, cnt, cnt_n;
  logic          mode;
  logic [2:0]    last, last_n, idx_n;
  logic [N-1:0]  gnt_n;
  logic          vld_n;
  logic [2:0]    pick_idx;
  logic          pick_any;
  state_t        state, state_n;

  // Button events are registered, giving one extra edge of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_d  <= '0;
      ev     <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
      ev     <= btn_s2 & ~btn_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quantum <= QW'(Q_RST);
      mode    <= 1'b0;
    end else begin
      if (ev[BTN_QUP] && !ev[BTN_QDN] &&
          quantum != QW'(Q_MAX))
        quantum <= quantum + QW'(1);
      else if (ev[BTN_QDN] && !ev[BTN_QUP] &&
               quantum != QW'(Q_MIN))
        quantum <= quantum - QW'(1);
      mode <= mode ^ ev[BTN_MODE];
    end
  end

  arb_pick u_pick (
    .req  (sw_s2),
    .last (last),
    .mode (mode),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      last      <= 3'd7;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      gnt_valid <= vld_n;
      last      <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    vld_n   = gnt_valid;
    last_n  = last;
    case (state)
      IDLE: begin
        if (ev[BTN_PAUSE]) begin
          state_n = PAUSE;
        end else if (pick_any) begin
          state_n = GRANT;
          cnt_n   = quantum;
          gnt_n   = N'(1) << pick_idx;
          idx_n   = pick_idx;
          vld_n   = 1'b1;
        end
      end
      GRANT: begin
        cnt_n = cnt - QW'(1);
        // Pausing keeps last so RR resumes at the same requester.
        if (ev[BTN_PAUSE]) begin
          state_n = PAUSE;
          gnt_n   = '0;
          vld_n   = 1'b0;
        end else if (ev[BTN_SKIP] || !sw_s2[gnt_idx] ||
                     cnt == QW'(1)) begin
          state_n = IDLE;
          last_n  = gnt_idx;
          gnt_n   = '0;
          vld_n   = 1'b0;
        end
      end
      PAUSE: begin
        if (ev[BTN_PAUSE]) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        vld_n   = 1'b0;
      end
    endcase
  end

  assign ledr = {1'b0, state == PAUSE, mode, gnt_valid,
                 quantum[3:0], gnt[7:0]};

endmodule

// File: tb/tb_sw_rr_arbiter.sv
// Directed self-checking bench for sw_rr_arbiter.
// Each task drives one scenario and checks hand-computed values.
module tb_sw_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  btn = '0;
  logic [7:0]  sw  = '0;
  logic [7:0]  gnt;
  logic [2:0]  gnt_idx;
  logic        gnt_valid;
  logic [15:0] ledr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sw_rr_arbiter #(.N(8), .QW(4), .Q_RST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .sw        (sw),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .ledr      (ledr)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    sw  = '0;
    btn = '0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    tick(1);
    btn = '0;
    tick(3);
  endtask

  task automatic test_reset;
    sw  = '0;
    btn = '0;
    rst = 1'b0;
    tick(2);
    n_chk++;
    if (ledr !== 16'h0400) begin
      n_fail++;
      $display("FAIL reset_ledr: got %h want 0400", ledr);
    end
    n_chk++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: got %h/%0d/%b want 00/0/0",
               gnt, gnt_idx, gnt_valid);
    end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_single;
    do_reset();
    sw = 8'h04;
    tick(2);
    n_chk++;
    if (gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat: valid %b after edge1 want 0", gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2 || ledr[11:8] !== 4'd4) begin
      n_fail++;
      $display("FAIL single_gnt: got %h/%0d/q%0d want 04/2/q4",
               gnt, gnt_idx, ledr[11:8]);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1);
      n_chk++;
      if (gnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single_hold%0d: valid %b want 1", k, gnt_valid);
      end
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: valid %b want 0", gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL single_regrant: got %b/%0d want 1/2",
               gnt_valid, gnt_idx);
    end
    sw = '0;
    tick(4);
  endtask

  task automatic test_rr;
    logic [2:0] exp;
    do_reset();
    sw = 8'h81;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick(5);
      exp = (k % 2 == 0) ? 3'd0 : 3'd7;
      n_chk++;
      if (gnt_valid !== 1'b1 || gnt_idx !== exp) begin
        n_fail++;
        $display("FAIL rr_turn%0d: got %b/%0d want 1/%0d",
                 k, gnt_valid, gnt_idx, exp);
      end
    end
    sw = '0;
    tick(4);
  endtask

  task automatic test_fixed;
    do_reset();
    press(5'b10000);
    n_chk++;
    if (ledr[13] !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_led: got %b want 1", ledr[13]);
    end
    sw = 8'h81;
    tick(3);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick(5);
      n_chk++;
      if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
        n_fail++;
        $display("FAIL fixed_turn%0d: got %h/%0d want 80/7",
                 k, gnt, gnt_idx);
      end
    end
    sw = '0;
    tick(4);
  endtask

  task automatic test_skip_drop;
    do_reset();
    for (int k = 0; k < 11; k++) press(5'b00100);
    n_chk++;
    if (ledr[11:8] !== 4'd15) begin
      n_fail++;
      $display("FAIL skip_q: got %0d want 15", ledr[11:8]);
    end
    sw = 8'h01;
    tick(3);
    btn = 5'b00010;
    tick(1);
    btn = '0;
    tick(2);
    n_chk++;
    if (gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_early: valid %b after edge2 want 1", gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_fall: valid %b after edge3 want 0", gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_regrant: valid %b want 1", gnt_valid);
    end
    sw = '0;
    tick(2);
    n_chk++;
    if (gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_early: valid %b after edge1 want 1", gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_fall: valid %b after edge2 want 0", gnt_valid);
    end
    tick(2);
  endtask

  task automatic test_quantum;
    do_reset();
    for (int k = 0; k < 20; k++) press(5'b00100);
    n_chk++;
    if (ledr[11:8] !== 4'd15) begin
      n_fail++;
      $display("FAIL q_max: got %0d want 15", ledr[11:8]);
    end
    for (int k = 0; k < 20; k++) press(5'b01000);
    n_chk++;
    if (ledr[11:8] !== 4'd1) begin
      n_fail++;
      $display("FAIL q_min: got %0d want 1", ledr[11:8]);
    end
    sw = 8'h01;
    tick(3);
    n_chk++;
    if (gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL q1_on: valid %b want 1", gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL q1_off: valid %b want 0", gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL q1_again: valid %b want 1", gnt_valid);
    end
    sw = '0;
    tick(4);
    press(5'b01100);
    n_chk++;
    if (ledr[11:8] !== 4'd1) begin
      n_fail++;
      $display("FAIL q_both: got %0d want 1", ledr[11:8]);
    end
    press(5'b00100);
    n_chk++;
    if (ledr[11:8] !== 4'd2) begin
      n_fail++;
      $display("FAIL q_up: got %0d want 2", ledr[11:8]);
    end
  endtask

  task automatic test_pause_reset;
    do_reset();
    sw  = 8'h81;
    btn = 5'b00001;
    tick(3);
    btn = '0;
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL pause_pre: got %b/%0d want 1/0", gnt_valid, gnt_idx);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b0 || ledr[14] !== 1'b1 || gnt !== 8'h00) begin
      n_fail++;
      $display("FAIL pause_enter: got v%b p%b g%h want v0 p1 g00",
               gnt_valid, ledr[14], gnt);
    end
    tick(6);
    n_chk++;
    if (gnt_valid !== 1'b0 || ledr[14] !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_hold: got v%b p%b want v0 p1",
               gnt_valid, ledr[14]);
    end
    press(5'b00001);
    n_chk++;
    if (ledr[14] !== 1'b0 || gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_exit: got p%b v%b want p0 v0",
               ledr[14], gnt_valid);
    end
    tick(1);
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL pause_resume: got %b/%0d want 1/0",
               gnt_valid, gnt_idx);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if (ledr !== 16'h0400 || gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got %h/%b want 0400/0", ledr, gnt_valid);
    end
    tick(1);
    rst = 1'b1;
    sw  = '0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_fixed();
    test_skip_drop();
    test_quantum();
    test_pause_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_rr_arbiter.md
# sw_rr_arbiter

Round-robin / fixed-priority arbiter that shares one grant slot among eight switch requesters (`sw[7:0]`) on the nvboard encoder example. It is driven by board buttons for pause, skip, quantum adjust and mode select. Grant state and configuration are shown on the 16 LEDs. It is the sequencing layer above the switch priority encoder: it holds each grant for a programmable number of cycles instead of reporting the highest set switch combinationally.

## Interface
Parameters:
- `N`, 8: number of requesters. Fixed at 8 in this revision.
- `QW`, 4: quantum counter width.
- `Q_RST`, 4: quantum value after reset.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-low (asserted when 0).
- `btn`  in  5  buttons. Asynchronous inputs.
  - `[0]` pause/resume toggle
  - `[1]` skip current grant
  - `[2]` quantum +1
  - `[3]` quantum −1
  - `[4]` mode toggle
- `sw`  in  8  request lines, one per requester. Asynchronous inputs.
- `gnt`  out  8  one-hot grant. All zero when `gnt_valid`=0.
- `gnt_idx`  out  3  index of the granted requester.
- `gnt_valid`  out  1  a grant is active.
- `ledr`  out  16  LED mapping:
  - `[7:0]`=`gnt`
  - `[11:8]`=`quantum`
  - `[12]`=`gnt_valid`
  - `[13]`=`mode` (0=RR, 1=fixed)
  - `[14]`=`paused`
  - `[15]`=0

## Operation
Input conditioning:
- `sw` and `btn` each pass a 2-flop synchronizer.
- Buttons get rising-edge detection on the synchronized value: one event per press. No debounce.

FSM states: IDLE, GRANT, PAUSE.
- **IDLE**
  - If synchronized request ≠ 0: pick a winner, load `cnt`=`quantum`, register `gnt`/`gnt_idx`/`gnt_valid`=1, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `cnt` decrements on every edge.
  - The grant is released and the FSM goes to IDLE when any of these holds:
    - the granted request bit is 0, or
    - `cnt`==1, or
    - a skip event occurs.
  - On release: `last` ← `gnt_idx`, `gnt_valid`←0.
  - IDLE always lasts at least one cycle before the next grant.
- **PAUSE**
  - Entered from any state on a pause event. `gnt_valid`=0; `last` and `quantum` are retained.
  - Pause event here → IDLE.
  - Skip and request changes are ignored. Quantum and mode buttons still apply.

Winner selection (combinational):
- RR mode: first set bit searching `last+1`, `last+2`, … with wrap modulo 8.
- Fixed mode: highest set index wins.

Quantum register:
- Range 1..15, reset value `Q_RST`.
- +1 saturates at 15; −1 saturates at 1.
- +1 and −1 in the same cycle: no change.
- A new value applies from the next grant; the running `cnt` is not affected.

Mode toggle:
- Takes effect at the next arbitration.
- Does not alter `last`.

Simultaneous events, highest precedence first: pause > skip > request drop / quantum expiry.

## Timing
Reset values:
- State=IDLE, `gnt`=0, `gnt_idx`=0, `gnt_valid`=0.
- `last`=7, so the first RR search starts at index 0.
- `quantum`=`Q_RST`, `mode`=0, `paused`=0.
- Synchronizers and edge detectors cleared.
- `ledr`=16'h0400.

Reset mid-grant: all outputs drop immediately and asynchronously. No release bookkeeping is kept.

Latencies (edge 0 is the first edge that samples the input high):
- Request → grant: `gnt_valid` is high after edge 2.
- Request drop: `gnt_valid` falls after edge 2.
- Button press: the action takes effect on the state/outputs after edge 3 (two sync edges plus one edge-detect edge).

Grant duration and spacing:
- With the request held, `gnt_valid` stays high exactly `quantum` cycles.
- Back-to-back grants are separated by exactly one low cycle.

All outputs are registered; `ledr` is a pure wire mapping of registers.

## Structure
- Package `sw_arb_pkg` holds:
  - the state enum (IDLE, GRANT, PAUSE)
  - button index constants (`BTN_PAUSE`=0, `BTN_SKIP`=1, `BTN_QUP`=2, `BTN_QDN`=3, `BTN_MODE`=4)
  - `Q_MIN`=1, `Q_MAX`=15
- Sub-module `arb_pick`: combinational. Inputs `req[7:0]`, `last[2:0]`, `mode`. Outputs `idx[2:0]`, `any`.
- The top module holds the synchronizers, edge detectors, FSM, counters and LED mapping.

## Test plan
- **Single requester:** reset, `quantum`=4, hold `sw`=8'h04.
  - `gnt`=8'h04, `gnt_idx`=2, high 4 cycles, 1 low, repeating.
  - `ledr[11:8]`=4.
- **RR rotation:** `sw`=8'h81 held, RR mode.
  - Grants alternate index 0, 7, 0, 7, starting with 0 (since `last`=7 after reset).
- **Fixed mode:** press `btn[4]`, `sw`=8'h81 held.
  - Only index 7 is granted.
  - `ledr[13]`=1.
- **Skip and drop:**
  - Skip press during a grant with `quantum`=15 → `gnt_valid` falls 3 edges after the press.
  - Dropping `sw[idx]` mid-grant → `gnt_valid` falls 2 edges after the drop.
- **Quantum saturation:** 20 presses of `btn[2]` → `quantum`=15. 20 presses of `btn[3]` → `quantum`=1.
- **Pause mid-grant and reset:**
  - Pause during a grant → `gnt_valid`=0 and `ledr[14]`=1. Resume → grant restarts from IDLE with RR order preserved.
  - Asserting `rst` (low) mid-grant → `ledr`=16'h0400 immediately.
